// File: rtl/pipeline_perf_monitor.sv
// Run-cycle / pipeline-event monitor with a cycle budget, last retired PC tracking,
// and a 4-phase snapshot handshake that freezes all counts into shadow registers.
module pipeline_perf_monitor #(
  parameter int CNT_W      = 32,
  parameter int N_EVT      = 2,
  parameter int PC_W       = 32,
  parameter int MAX_CYCLES = 30,
  localparam int SEL_W     = $clog2(N_EVT + 2) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [N_EVT-1:0] evt_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             snap_req_i,
  output logic             snap_ack_o,
  input  logic [SEL_W-1:0] rd_sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             run_o,
  output logic             halt_o,
  output logic [N_EVT-1:0] ovf_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] BUDGET     = CNT_W'(MAX_CYCLES);
  localparam bit               HAS_BUDGET = (MAX_CYCLES != 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   evt_q [N_EVT];
  logic [CNT_W-1:0]   evt_d [N_EVT];
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [N_EVT-1:0]   ovf_q, ovf_d;
  logic [CNT_W-1:0]   sh_cyc_q;
  logic [CNT_W-1:0]   sh_evt_q [N_EVT];
  logic [PC_W-1:0]    sh_pc_q;
  logic               ack_q;
  logic [CNT_W-1:0]   rd_q, rd_d;
  logic               snap_fire_s;

  // Live counter update and FSM next state; clear overrides everything else.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    evt_d   = evt_q;
    pc_d    = pc_q;
    ovf_d   = ovf_q;
    if (state_q == S_RUN) begin
      if (cyc_q != CNT_MAX) begin
        cyc_d = cyc_q + CNT_W'(1);
      end else begin
        cyc_d = cyc_q;
      end
      for (int k = 0; k < N_EVT; k++) begin
        if (evt_i[k] && (evt_q[k] == CNT_MAX)) begin
          ovf_d[k] = 1'b1;
        end else if (evt_i[k]) begin
          evt_d[k] = evt_q[k] + CNT_W'(1);
        end else begin
          evt_d[k] = evt_q[k];
        end
      end
      pc_d = pc_i;
    end else begin
      pc_d = pc_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
        else         state_d = S_IDLE;
      end
      S_RUN: begin
        if (HAS_BUDGET && (cyc_d == BUDGET)) state_d = S_HALT;
        else if (!start_i)                   state_d = S_IDLE;
        else                                 state_d = S_RUN;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (clear_i) begin
      state_d = S_IDLE;
      cyc_d   = '0;
      pc_d    = '0;
      ovf_d   = '0;
      for (int k = 0; k < N_EVT; k++) evt_d[k] = '0;
    end else begin
      ovf_d = ovf_d;
    end
  end

  assign snap_fire_s = snap_req_i & ~ack_q;

  // Readout mux over the frozen shadows.
  always_comb begin
    rd_d = '0;
    if (rd_sel_i == '0) begin
      rd_d = sh_cyc_q;
    end else if (rd_sel_i == SEL_W'(N_EVT + 1)) begin
      rd_d = CNT_W'(sh_pc_q);
    end else begin
      for (int k = 0; k < N_EVT; k++) begin
        if (rd_sel_i == SEL_W'(k + 1)) rd_d = sh_evt_q[k];
        else                           rd_d = rd_d;
      end
    end
  end

  // All state; shadows load only on the first request cycle of a handshake.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      pc_q     <= '0;
      ovf_q    <= '0;
      sh_cyc_q <= '0;
      sh_pc_q  <= '0;
      ack_q    <= 1'b0;
      rd_q     <= '0;
      for (int k = 0; k < N_EVT; k++) begin
        evt_q[k]    <= '0;
        sh_evt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      evt_q   <= evt_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      ack_q   <= snap_req_i;
      rd_q    <= rd_d;
      if (snap_fire_s) begin
        sh_cyc_q <= cyc_d;
        sh_evt_q <= evt_d;
        sh_pc_q  <= pc_d;
      end else begin
        sh_cyc_q <= sh_cyc_q;
      end
    end
  end

  assign run_o      = (state_q == S_RUN);
  assign halt_o     = (state_q == S_HALT);
  assign snap_ack_o = ack_q;
  assign rd_data_o  = rd_q;
  assign ovf_o      = ovf_q;

endmodule
